// File: rtl/proc_ctrl.sv
// proc_ctrl: multi-cycle fetch/decode/execute controller for the 16-bit processor.
// Owns pc, the 16-entry register file and the zero flag; all memory traffic shares one req/ready port.
module proc_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] START_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic              zero,
    input  logic [3:0]        dbg_rsel,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_MEMOP,
        S_HALT
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]        op;
    logic [3:0]        rs;
    logic [3:0]        rd;
    logic [ADDR_W-1:0] opnd_addr;
    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] alu_res;
    logic              accept;

    assign accept    = mem_req && mem_ready;
    assign dbg_rdata = regs[dbg_rsel];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (accept) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_ADD, OP_SUB, OP_MOV:             next_state = S_FETCH;
                    OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ: next_state = S_OPERAND;
                    default:                            next_state = S_HALT;
                endcase
            end
            S_OPERAND: begin
                if (accept) begin
                    next_state = (op == OP_LD || op == OP_ST) ? S_MEMOP : S_FETCH;
                end
            end
            S_MEMOP: begin
                if (accept) begin
                    next_state = S_FETCH;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Requests are pure functions of state, so a reset edge drops mem_req immediately.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b1;
        halted    = 1'b0;
        case (state)
            S_IDLE: busy = 1'b0;
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            S_FETCH, S_OPERAND: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            S_MEMOP: begin
                mem_req  = 1'b1;
                mem_addr = opnd_addr;
                if (op == OP_ST) begin
                    mem_we    = 1'b1;
                    mem_wdata = regs[rd];
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_ADD:  alu_res = regs[rd] + regs[rs];
            OP_SUB:  alu_res = regs[rd] - regs[rs];
            default: alu_res = regs[rs];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= START_PC;
            op        <= '0;
            rs        <= '0;
            rd        <= '0;
            opnd_addr <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc      <= START_PC;
                        illegal <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (accept) begin
                        op <= mem_rdata[15:12];
                        rs <= mem_rdata[7:4];
                        rd <= mem_rdata[3:0];
                        pc <= pc + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_MOV: begin
                            regs[rd] <= alu_res;
                            zero     <= (alu_res == '0);
                        end
                        OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JZ, OP_HALT: begin
                        end
                        default: illegal <= 1'b1;
                    endcase
                end
                S_OPERAND: begin
                    if (accept) begin
                        opnd_addr <= mem_rdata[ADDR_W-1:0];
                        pc        <= pc + ADDR_W'(1);
                        case (op)
                            OP_LDI: begin
                                regs[rd] <= mem_rdata;
                                zero     <= (mem_rdata == '0);
                            end
                            OP_JMP: pc <= mem_rdata[ADDR_W-1:0];
                            OP_JZ: begin
                                if (zero) begin
                                    pc <= mem_rdata[ADDR_W-1:0];
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_MEMOP: begin
                    if (accept && op == OP_LD) begin
                        regs[rd] <= mem_rdata;
                        zero     <= (mem_rdata == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed bench for proc_ctrl: two instances (START_PC 0 and FE), each with a small memory model.
module tb_proc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start2;
    logic        mem_req, mem_we, mem_ready;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_wdata, mem_rdata, dbg_rdata;
    logic        busy, halted, illegal, zero;
    logic [3:0]  dbg_rsel;
    logic        mem_req2, mem_we2, mem_ready2;
    logic [7:0]  mem_addr2, pc2;
    logic [15:0] mem_wdata2, mem_rdata2, dbg_rdata2;
    logic        busy2, halted2, illegal2, zero2;
    logic [3:0]  dbg_rsel2;

    logic [15:0] mem  [0:255];
    logic [15:0] mem2 [0:255];
    int          wait_cfg;
    int          wait_cnt  = 0;
    int          write_cnt = 0;
    bit          block_we;
    bit          clr_mem, ld_en, ld_sel;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    proc_ctrl #(.ADDR_W(8), .DATA_W(16), .START_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .busy(busy), .halted(halted), .illegal(illegal), .zero(zero),
        .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
    );

    proc_ctrl #(.ADDR_W(8), .DATA_W(16), .START_PC(8'hFE)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
        .pc(pc2), .busy(busy2), .halted(halted2), .illegal(illegal2), .zero(zero2),
        .dbg_rsel(dbg_rsel2), .dbg_rdata(dbg_rdata2)
    );

    // Memory for dut: ready after wait_cfg stalled cycles; block_we withholds ready on writes.
    assign mem_ready = mem_req && (wait_cnt >= wait_cfg) && !(block_we && mem_we);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (clr_mem && !ld_sel) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (ld_en && !ld_sel) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            write_cnt     <= write_cnt + 1;
        end
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    assign mem_ready2 = mem_req2;
    assign mem_rdata2 = mem2[mem_addr2];

    always @(posedge clk) begin
        if (clr_mem && ld_sel) begin
            for (int i = 0; i < 256; i++) mem2[i] <= '0;
        end else if (ld_en && ld_sel) begin
            mem2[ld_addr] <= ld_data;
        end else if (mem_req2 && mem_ready2 && mem_we2) begin
            mem2[mem_addr2] <= mem_wdata2;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearMem(input bit sel);
        ld_sel  = sel;
        clr_mem = 1'b1;
        @(negedge clk);
        clr_mem = 1'b0;
    endtask

    task automatic loadWord(input bit sel, input logic [7:0] a, input logic [15:0] d);
        ld_sel  = sel;
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic loadProgram(input logic [15:0] words [$]);
        clearMem(1'b0);
        foreach (words[i]) loadWord(1'b0, 8'(i), words[i]);
    endtask

    task automatic readReg(input logic [3:0] r, output logic [15:0] v);
        dbg_rsel = r;
        #1;
        v = dbg_rdata;
    endtask

    // Pulses start, optionally re-pulses it at cycle 'spur', and counts cycles from busy to halted.
    task automatic applyStimulus(input int spur, output int lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!halted && lat < 300) begin
            start = (lat == spur);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!halted) checkOutput("halt_timeout", halted, 1);
    endtask

    initial begin
        int          lat, cyc, wr_before;
        bit          pend;
        logic [7:0]  s_addr;
        logic        s_we;
        logic [15:0] s_wdata, v;

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
        dbg_rsel = '0; dbg_rsel2 = '0;
        wait_cfg = 0; block_we = 1'b0;
        clr_mem = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        @(negedge clk);
        clearMem(1'b0);
        clearMem(1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_illegal", illegal, 0);
        checkOutput("rst_zero", zero, 0);
        checkOutput("rst_pc", pc, 8'h00);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_addr", mem_addr, 8'h00);
        readReg(4'd0, v);  checkOutput("rst_r0", v, 16'h0000);
        readReg(4'd15, v); checkOutput("rst_r15", v, 16'h0000);

        $display("[TB] zero-wait program with a start pulse while busy");
        loadProgram('{16'h3000, 16'h0001, 16'h3001, 16'h0003, 16'h0010, 16'hF000});
        applyStimulus(4, lat);
        checkOutput("t1_latency", lat, 10);
        readReg(4'd0, v); checkOutput("t1_r0", v, 16'h0004);
        readReg(4'd1, v); checkOutput("t1_r1", v, 16'h0003);
        checkOutput("t1_halted", halted, 1);
        checkOutput("t1_busy", busy, 0);
        checkOutput("t1_pc", pc, 8'h06);
        checkOutput("t1_zero", zero, 0);
        checkOutput("t1_illegal", illegal, 0);

        $display("[TB] subtract to zero, then MOV clears zero");
        loadProgram('{16'h3002, 16'h0005, 16'h1022, 16'hF000});
        applyStimulus(-1, lat);
        readReg(4'd2, v); checkOutput("sub_r2", v, 16'h0000);
        checkOutput("sub_zero", zero, 1);
        checkOutput("sub_pc", pc, 8'h04);
        loadProgram('{16'h2012, 16'hF000});
        checkOutput("zero_kept_idle", zero, 1);
        applyStimulus(-1, lat);
        checkOutput("mov_latency", lat, 4);
        readReg(4'd2, v); checkOutput("mov_r2", v, 16'h0003);
        checkOutput("mov_zero", zero, 0);

        $display("[TB] two wait states per transfer, LD then ST");
        loadProgram('{16'h4003, 16'h0080, 16'h5003, 16'h0081, 16'hF000});
        loadWord(1'b0, 8'h80, 16'hABCD);
        wait_cfg = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; pend = 1'b0; s_addr = '0; s_we = 1'b0; s_wdata = '0;
        while (!halted && cyc < 400) begin
            if (pend) begin
                checkOutput("wait_addr_stable", mem_addr, s_addr);
                checkOutput("wait_we_stable", mem_we, s_we);
                checkOutput("wait_wdata_stable", mem_wdata, s_wdata);
            end
            pend = mem_req && !mem_ready;
            s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
            @(negedge clk);
            cyc++;
        end
        checkOutput("wait_halted", halted, 1);
        wait_cfg = 0;
        readReg(4'd3, v); checkOutput("wait_r3", v, 16'hABCD);
        checkOutput("wait_mem81", mem[8'h81], 16'hABCD);
        checkOutput("wait_pc", pc, 8'h05);

        $display("[TB] JZ taken");
        loadProgram('{16'h1000, 16'h7000, 16'h0010, 16'h3005, 16'hDEAD, 16'hF000});
        loadWord(1'b0, 8'h10, 16'h3005);
        loadWord(1'b0, 8'h11, 16'h1234);
        loadWord(1'b0, 8'h12, 16'hF000);
        applyStimulus(-1, lat);
        readReg(4'd5, v); checkOutput("jz_taken_r5", v, 16'h1234);
        checkOutput("jz_taken_pc", pc, 8'h13);

        $display("[TB] JZ not taken");
        loadProgram('{16'h3000, 16'h0007, 16'h0000, 16'h7000, 16'h0010, 16'h3005, 16'hDEAD, 16'hF000});
        loadWord(1'b0, 8'h10, 16'h3005);
        loadWord(1'b0, 8'h11, 16'h1234);
        loadWord(1'b0, 8'h12, 16'hF000);
        applyStimulus(-1, lat);
        readReg(4'd0, v); checkOutput("jz_nt_r0", v, 16'h000E);
        readReg(4'd5, v); checkOutput("jz_nt_r5", v, 16'hDEAD);
        checkOutput("jz_nt_pc", pc, 8'h08);

        $display("[TB] illegal opcode at address 5");
        loadProgram('{16'h3002, 16'h0009, 16'h2020, 16'h0000, 16'h2001, 16'h8123});
        applyStimulus(-1, lat);
        checkOutput("ill_latency", lat, 11);
        readReg(4'd1, v); checkOutput("ill_r1", v, 16'h0012);
        checkOutput("ill_halted", halted, 1);
        checkOutput("ill_illegal", illegal, 1);
        checkOutput("ill_pc", pc, 8'h06);

        $display("[TB] reset while ST is stalled in MEMOP");
        loadProgram('{16'h3003, 16'hBEEF, 16'h5003, 16'h0090, 16'hF000});
        loadWord(1'b0, 8'h90, 16'h1111);
        block_we = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(mem_req && mem_we) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("st_reached", mem_req && mem_we, 1);
        checkOutput("st_addr", mem_addr, 8'h90);
        checkOutput("st_wdata", mem_wdata, 16'hBEEF);
        checkOutput("illegal_cleared", illegal, 0);
        repeat (2) @(negedge clk);
        wr_before = write_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mrst_mem_req", mem_req, 0);
        checkOutput("mrst_mem_we", mem_we, 0);
        checkOutput("mrst_mem_addr", mem_addr, 8'h00);
        checkOutput("mrst_mem_wdata", mem_wdata, 16'h0000);
        checkOutput("mrst_busy", busy, 0);
        checkOutput("mrst_halted", halted, 0);
        checkOutput("mrst_pc", pc, 8'h00);
        readReg(4'd3, v); checkOutput("mrst_r3", v, 16'h0000);
        rst_n = 1'b1;
        block_we = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mrst_no_write", write_cnt, wr_before);
        checkOutput("mrst_mem90", mem[8'h90], 16'h1111);
        checkOutput("mrst_stays_idle", busy, 0);

        $display("[TB] START_PC FE with operand fetched at FF");
        loadWord(1'b1, 8'hFE, 16'h3001);
        loadWord(1'b1, 8'hFF, 16'h0042);
        loadWord(1'b1, 8'h00, 16'hF000);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0;
        while (!halted2 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("wrap_latency", lat, 5);
        dbg_rsel2 = 4'd1;
        #1;
        checkOutput("wrap_r1", dbg_rdata2, 16'h0042);
        checkOutput("wrap_halted", halted2, 1);
        checkOutput("wrap_pc", pc2, 8'h01);
        checkOutput("wrap_illegal", illegal2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
